assist_sw_sequencer: RTL and testbench
======================================

// Module: assist_sw_sequencer
// PURPOSE
//  Transmit side of the 4-bit one-hot switch-command interface consumed by the assistive-control FSM.
//  Accepts a target position (0..3) via valid/ready and emits the one-hot sw codes that step the consumer
//  around its S0->S1->S2->S3->S0 ring. Each code is held long enough to pass the consumer's debouncer.
//  Keeps a mirror of the consumer position. Drives stimulus from the headset/sensor front end and the bench.
// PARAMETERS
//  HOLD_CYCLES  8  cycles each one-hot code is driven; must be >=1, and >=6 to clear consumer debounce (5)
//  GAP_CYCLES   4  cycles of sw=0 after each code; 0 = no gap, next code follows directly
//  SW_W         4  switch bus width; fixed at 4 (one bit per ring position)
// PORTS
//  clk         in   1  clock
//  reset       in   1  asynchronous, active-high reset
//  cmd_valid   in   1  target request valid
//  cmd_target  in   2  requested consumer position (0..3)
//  cmd_ready   out  1  high in IDLE only; transfer on cmd_valid & cmd_ready at posedge
//  sw          out  4  one-hot code to consumer, 0 when not holding
//  pos         out  2  mirrored consumer position
//  busy        out  1  high in HOLD/GAP
//  done        out  1  one-cycle pulse when a command completes
//  abort       in   1  present only with ASSIST_SEQ_ABORT_EN
// BEHAVIOUR
//  Reset (async): state=IDLE, sw=0, pos=0, busy=0, done=0, counter=0; cmd_ready=1 after reset.
//  All outputs registered except cmd_ready (decode of state==IDLE).
//  States: IDLE, HOLD, GAP.
//  IDLE: on accept, steps=(cmd_target-pos) mod 4, computed in 2-bit wrap arithmetic.
//    steps==0 -> stay IDLE, done=1 next cycle, sw stays 0.
//    steps!=0 -> HOLD next cycle with sw=1<<pos, counter=HOLD_CYCLES-1.
//  HOLD: sw held constant; counter decrements each cycle. At counter==0:
//    pos<=pos+1 (3 wraps to 0), steps<=steps-1, sw<=0.
//    GAP_CYCLES>0 -> GAP, counter=GAP_CYCLES-1.
//    GAP_CYCLES==0 and steps>1 -> HOLD again with the next code.
//    GAP_CYCLES==0 and steps==1 -> IDLE with done=1.
//  GAP: sw=0; at counter==0, steps>0 -> HOLD with the next code; steps==0 -> IDLE with done=1.
//  Timing: accept at edge k; sw valid from k+1 for HOLD_CYCLES cycles.
//    Per-step duration = HOLD_CYCLES+GAP_CYCLES; done at k+1+steps*(HOLD+GAP); cmd_ready returns with done.
//  Codes walk the ring in order only, never skip: target 1 from pos 3 emits 1000 then 0001.
//  cmd_valid while busy is ignored; no queueing, and the cmd_target change is not sampled.
//  done and cmd_valid in the same cycle: the new command is accepted (ready already high).
//  Reset mid-operation: immediate return to reset values, pos=0, matching the consumer, which shares this reset.
//  busy=1 exactly when state!=IDLE.
// CONFIGURATION
//  ASSIST_SEQ_ABORT_EN defined: abort port exists.
//    abort in HOLD -> sw=0 next cycle; pos not advanced; go to GAP with full GAP_CYCLES, then IDLE.
//    abort in GAP -> finish the gap, then IDLE.
//    A command ended by abort gives no done pulse; abort in IDLE has no effect.
//  Not defined: no abort port; commands always run to completion.
// STRUCTURE
//  Package assist_pkg: state enum {IDLE,HOLD,GAP}; SW_W=4, POS_W=2; function onehot(pos) -> 4'b1<<pos.
//    The consumer FSM reuses this package.
//  Sub-module assist_step_timer: loadable down-counter.
//    Ports: load, load_val, zero flag; width $clog2(max(HOLD,GAP)+1).
//  Top holds the FSM, the pos/steps registers and the output registers.
// TESTING
//  Reset, then cmd_target=2 -> sw=0001 for 8 cycles, 0 for 4, 0010 for 8, 0 for 4; done at k+25; pos=2.
//  pos=3, cmd_target=1 -> codes 1000 then 0001; pos wraps to 1; done after 2 steps.
//  cmd_target==pos -> sw stays 0, done the cycle after accept, busy never asserts.
//  cmd_valid toggled with a new target while busy -> ignored; only the first command executes; ready low throughout.
//  reset asserted mid-HOLD -> same cycle: sw=0, pos=0, busy=0; next command runs from pos 0.
//  Connected to the consumer FSM, walk all 4 targets: consumer led==1<<pos after each done.
//    ASSIST_SEQ_ABORT_EN build: abort mid-HOLD -> sw=0 next cycle, pos unchanged, no done.

Source files
------------

// File: rtl/assist_pkg.sv
// Shared types for the assistive switch-command interface; the consumer FSM imports this package as well.
package assist_pkg;

  localparam int SW_W  = 4;
  localparam int POS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [SW_W-1:0] onehot(input logic [POS_W-1:0] p);
    return {{(SW_W-1){1'b0}}, 1'b1} << p;
  endfunction

endpackage

// File: rtl/assist_step_timer.sv
// Loadable down-counter that times the hold and gap phases; it parks at zero until reloaded.
module assist_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/assist_sw_sequencer.sv
// Walks the consumer around its one-hot ring to a requested position, one debounce-safe code at a time.
// Optional abort input is built in when ASSIST_SEQ_ABORT_EN is defined.
module assist_sw_sequencer #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int SW_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_target,
`ifdef ASSIST_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            cmd_ready,
  output logic [SW_W-1:0] sw,
  output logic [1:0]      pos,
  output logic            busy,
  output logic            done
);
  import assist_pkg::*;

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [1:0]       steps;
  logic [1:0]       req_steps;
  logic             aborted;
  logic             abort_req;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

`ifdef ASSIST_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Ring distance in 2-bit wrap arithmetic, so the walk is always forward.
  assign req_steps = cmd_target - pos;
  assign cmd_ready = (state == IDLE);

  assist_step_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    case (state)
      IDLE: tmr_load = cmd_valid && (req_steps != 2'd0);
      HOLD: begin
        if (abort_req) begin
          tmr_load = (GAP_CYCLES > 0);
          tmr_val  = GAP_LOAD;
        end else if (tmr_zero) begin
          if (GAP_CYCLES > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            tmr_load = (steps > 2'd1);
          end
        end
      end
      GAP: tmr_load = tmr_zero && (steps != 2'd0) && !abort_req;
      default: ;
    endcase
  end

  // An aborted command still finishes its gap so the consumer sees a clean release, but never pulses done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sw      <= '0;
      pos     <= 2'd0;
      steps   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (req_steps == 2'd0) begin
              done <= 1'b1;
            end else begin
              state   <= HOLD;
              busy    <= 1'b1;
              sw      <= onehot(pos);
              steps   <= req_steps;
              aborted <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (abort_req) begin
            sw      <= '0;
            steps   <= 2'd0;
            aborted <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tmr_zero) begin
            pos   <= pos + 1'b1;
            steps <= steps - 1'b1;
            sw    <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else if (steps > 2'd1) begin
              sw <= onehot(pos + 1'b1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (abort_req) begin
            steps   <= 2'd0;
            aborted <= 1'b1;
          end
          if (tmr_zero) begin
            if ((steps != 2'd0) && !abort_req) begin
              state <= HOLD;
              sw    <= onehot(pos);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= !aborted && !abort_req;
            end
          end
        end
        default: begin
          state <= IDLE;
          sw    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assist_sw_sequencer.sv
// Directed bench for assist_sw_sequencer with a small debouncing consumer model on the sw bus.
// Abort scenario is included when ASSIST_SEQ_ABORT_EN is defined.
module tb_assist_sw_sequencer;

  localparam int H    = 8;
  localparam int G    = 4;
  localparam int STEP = H + G;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_target;
  logic       cmd_ready;
  logic [3:0] sw;
  logic [1:0] pos;
  logic       busy;
  logic       done;
`ifdef ASSIST_SEQ_ABORT_EN
  logic       abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assist_sw_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .SW_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_target (cmd_target),
`ifdef ASSIST_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .cmd_ready  (cmd_ready),
    .sw         (sw),
    .pos        (pos),
    .busy       (busy),
    .done       (done)
  );

  // Consumer model: advances one ring position after a code matching its position is stable for 5 cycles.
  logic [1:0] cons_pos;
  logic [3:0] prev_sw;
  int         stable;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cons_pos <= 2'd0;
      prev_sw  <= 4'd0;
      stable   <= 0;
    end else begin
      prev_sw <= sw;
      if (sw == 4'd0) begin
        stable <= 0;
      end else if (sw != prev_sw) begin
        stable <= 1;
      end else begin
        stable <= stable + 1;
        if (stable + 1 == 5 && sw == (4'b0001 << cons_pos)) cons_pos <= 2'(cons_pos + 2'd1);
      end
    end
  end

  function automatic logic [3:0] exp_sw(input int j, input logic [1:0] p0, input int steps);
    int         idx;
    logic [1:0] p;
    idx = j / STEP;
    p   = 2'(p0 + 2'(idx));
    if (idx < steps && (j % STEP) < H) return 4'b0001 << p;
    return 4'b0000;
  endfunction

  task automatic send_cmd(input logic [1:0] t);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = t;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = 2'd0;
`ifdef ASSIST_SEQ_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (sw !== 4'd0)  begin errors++; $display("[TB] FAIL reset_sw got=%b exp=0000", sw); end
    checks++; if (pos !== 2'd0) begin errors++; $display("[TB] FAIL reset_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_two_steps;
    send_cmd(2'd2);
    for (int j = 0; j <= 2 * STEP; j++) begin
      @(negedge clk);
      checks++; if (sw !== exp_sw(j, 2'd0, 2)) begin errors++; $display("[TB] FAIL two_steps_sw j=%0d got=%b exp=%b", j, sw, exp_sw(j, 2'd0, 2)); end
      checks++; if (done !== 1'(j == 2 * STEP)) begin errors++; $display("[TB] FAIL two_steps_done j=%0d got=%b", j, done); end
      checks++; if (busy !== 1'(j < 2 * STEP)) begin errors++; $display("[TB] FAIL two_steps_busy j=%0d got=%b", j, busy); end
    end
    checks++; if (pos !== 2'd2) begin errors++; $display("[TB] FAIL two_steps_pos got=%0d exp=2", pos); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL two_steps_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_wrap;
    send_cmd(2'd3);
    repeat (STEP + 1) @(negedge clk);
    checks++; if (pos !== 2'd3) begin errors++; $display("[TB] FAIL wrap_setup_pos got=%0d exp=3", pos); end
    send_cmd(2'd1);
    for (int j = 0; j <= 2 * STEP; j++) begin
      @(negedge clk);
      checks++; if (sw !== exp_sw(j, 2'd3, 2)) begin errors++; $display("[TB] FAIL wrap_sw j=%0d got=%b exp=%b", j, sw, exp_sw(j, 2'd3, 2)); end
      checks++; if (done !== 1'(j == 2 * STEP)) begin errors++; $display("[TB] FAIL wrap_done j=%0d got=%b", j, done); end
    end
    checks++; if (pos !== 2'd1) begin errors++; $display("[TB] FAIL wrap_pos got=%0d exp=1", pos); end
  endtask

  task automatic test_same_target;
    send_cmd(2'd1);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL same_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL same_busy got=%b exp=0", busy); end
    checks++; if (sw !== 4'd0)   begin errors++; $display("[TB] FAIL same_sw got=%b exp=0000", sw); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL same_done_pulse got=%b exp=0", done); end
    checks++; if (pos !== 2'd1)  begin errors++; $display("[TB] FAIL same_pos got=%0d exp=1", pos); end
  endtask

  task automatic test_busy_ignore;
    send_cmd(2'd2);
    for (int j = 0; j <= STEP; j++) begin
      @(negedge clk);
      checks++; if (cmd_ready !== 1'(j == STEP)) begin errors++; $display("[TB] FAIL ignore_ready j=%0d got=%b", j, cmd_ready); end
      checks++; if (sw !== exp_sw(j, 2'd1, 1)) begin errors++; $display("[TB] FAIL ignore_sw j=%0d got=%b exp=%b", j, sw, exp_sw(j, 2'd1, 1)); end
      if (j == 2) begin cmd_valid = 1'b1; cmd_target = 2'd0; end
      if (j == 6) cmd_target = 2'd3;
      if (j == 9) cmd_valid = 1'b0;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done got=%b exp=1", done); end
    checks++; if (pos !== 2'd2)  begin errors++; $display("[TB] FAIL ignore_pos got=%0d exp=2", pos); end
  endtask

  task automatic test_back_to_back;
    send_cmd(2'd3);
    for (int j = 0; j <= STEP; j++) @(negedge clk);
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done done=%b ready=%b exp=1/1", done, cmd_ready); end
    cmd_valid  = 1'b1;
    cmd_target = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int j = 0; j <= STEP; j++) begin
      @(negedge clk);
      checks++; if (sw !== exp_sw(j, 2'd3, 1)) begin errors++; $display("[TB] FAIL b2b_sw j=%0d got=%b exp=%b", j, sw, exp_sw(j, 2'd3, 1)); end
      checks++; if (done !== 1'(j == STEP)) begin errors++; $display("[TB] FAIL b2b_done j=%0d got=%b", j, done); end
    end
    checks++; if (pos !== 2'd0) begin errors++; $display("[TB] FAIL b2b_pos got=%0d exp=0", pos); end
  endtask

  task automatic test_reset_mid_hold;
    send_cmd(2'd3);
    for (int j = 0; j <= 14; j++) @(negedge clk);
    checks++; if (sw !== 4'b0010 || pos !== 2'd1) begin errors++; $display("[TB] FAIL midhold_pre sw=%b pos=%0d exp=0010/1", sw, pos); end
    #1 reset = 1'b1;
    #1;
    checks++; if (sw !== 4'd0)       begin errors++; $display("[TB] FAIL midhold_sw got=%b exp=0000", sw); end
    checks++; if (pos !== 2'd0)      begin errors++; $display("[TB] FAIL midhold_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL midhold_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midhold_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    send_cmd(2'd1);
    for (int j = 0; j <= STEP; j++) begin
      @(negedge clk);
      checks++; if (sw !== exp_sw(j, 2'd0, 1)) begin errors++; $display("[TB] FAIL midhold_rerun_sw j=%0d got=%b exp=%b", j, sw, exp_sw(j, 2'd0, 1)); end
    end
    checks++; if (done !== 1'b1 || pos !== 2'd1) begin errors++; $display("[TB] FAIL midhold_rerun_end done=%b pos=%0d exp=1/1", done, pos); end
  endtask

  task automatic test_walk;
    for (int t = 0; t < 4; t++) begin
      int n;
      send_cmd(2'(t));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 100);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL walk_timeout target=%0d got_done=%b exp=1", t, done); end
      checks++; if (pos !== 2'(t)) begin errors++; $display("[TB] FAIL walk_pos target=%0d got=%0d exp=%0d", t, pos, t); end
      checks++; if ((4'b0001 << cons_pos) !== (4'b0001 << t)) begin errors++; $display("[TB] FAIL walk_led target=%0d got=%b exp=%b", t, 4'b0001 << cons_pos, 4'b0001 << t); end
    end
  endtask

`ifdef ASSIST_SEQ_ABORT_EN
  task automatic test_abort;
    send_cmd(2'd0);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      checks++; if (sw !== ((j <= 3) ? 4'b1000 : 4'b0000)) begin errors++; $display("[TB] FAIL abort_sw j=%0d got=%b", j, sw); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done j=%0d got=%b exp=0", j, done); end
      checks++; if (busy !== 1'(j < 8)) begin errors++; $display("[TB] FAIL abort_busy j=%0d got=%b", j, busy); end
      checks++; if (pos !== 2'd3) begin errors++; $display("[TB] FAIL abort_pos j=%0d got=%0d exp=3", j, pos); end
      if (j == 3) abort = 1'b1;
      if (j == 4) abort = 1'b0;
    end
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_two_steps();
    test_wrap();
    test_same_target();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_hold();
    test_walk();
`ifdef ASSIST_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
